// File: rtl/mem_stage_ld_pkg.sv
// Shared definitions for the MEM load stage: load-size and FSM encodings,
// default stall-vector width and fixed stage-bus field widths.
package mem_stage_ld_pkg;

  // Load access size as carried on the EX bus.
  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } ld_size_e;

  // Load-response tracking: no load, load waiting on SRAM, data captured.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HAVE = 2'b10
  } ld_state_e;

  localparam int STALL_W_DEF = 6;   // default core stall-vector width
  localparam int PC_W        = 32;  // instruction PC width
  localparam int LD_SIZE_W   = 2;   // ex_ld_size width
  localparam int ADDR_LO_W   = 2;   // byte offset within the 32-bit lane

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: picks the addressed byte/half from the low
// 32 bits of the read word and sign- or zero-extends it to DATA_W.
// Only instantiated when MEM_LOAD_SUBWORD_EN is defined.
module mem_load_align
  import mem_stage_ld_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]    rdata,
  input  logic [LD_SIZE_W-1:0] size,
  input  logic                 ld_unsigned,
  input  logic [ADDR_LO_W-1:0] addr_lo,
  output logic [DATA_W-1:0]    aligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select and extension; half loads ignore addr_lo[0].
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = rdata[15:0];
    aligned   = rdata;
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    if (addr_lo[1]) half_lane = rdata[31:16];
    case (size)
      LD_BYTE: aligned = {{(DATA_W-8){~ld_unsigned & byte_lane[7]}}, byte_lane};
      LD_HALF: aligned = {{(DATA_W-16){~ld_unsigned & half_lane[15]}}, half_lane};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ld.sv
// MEM stage between EX and WB: latches the EX bus under the stall vector,
// waits for variable-latency data-SRAM read responses, aligns loads and
// drives the write-back and ID forwarding buses (with a pending flag).
// Sub-word alignment/extension is built only with MEM_LOAD_SUBWORD_EN.
module mem_stage_ld
  import mem_stage_ld_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int STALL_W = STALL_W_DEF,
  parameter int STG     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 ex_valid,
  input  logic [PC_W-1:0]      ex_pc,
  input  logic                 ex_load,
  input  logic [LD_SIZE_W-1:0] ex_ld_size,
  input  logic                 ex_ld_unsigned,
  input  logic [ADDR_LO_W-1:0] ex_addr_lo,
  input  logic                 ex_rf_we,
  input  logic [RF_AW-1:0]     ex_rf_waddr,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic                 dmem_rvalid,
  input  logic [DATA_W-1:0]    dmem_rdata,
  output logic                 stall_req,
  output logic                 wb_valid,
  output logic [PC_W-1:0]      wb_pc,
  output logic                 wb_rf_we,
  output logic [RF_AW-1:0]     wb_rf_waddr,
  output logic [DATA_W-1:0]    wb_rf_wdata,
  output logic                 fwd_we,
  output logic [RF_AW-1:0]     fwd_waddr,
  output logic [DATA_W-1:0]    fwd_wdata,
  output logic                 fwd_pending
);

  // Stage register fields.
  logic                 stg_valid;
  logic [PC_W-1:0]      stg_pc;
  logic                 stg_load;
  logic [LD_SIZE_W-1:0] stg_ld_size;
  logic                 stg_ld_unsigned;
  logic [ADDR_LO_W-1:0] stg_addr_lo;
  logic                 stg_rf_we;
  logic [RF_AW-1:0]     stg_rf_waddr;
  logic [DATA_W-1:0]    stg_result;

  ld_state_e         state, state_next;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] wdata;
  logic              capture;
  logic              bubble;
  logic              resp_take;

  assign capture   = ~stall[STG];
  assign bubble    = stall[STG] & ~stall[STG+1];
  assign resp_take = (state == WAIT) & dmem_rvalid;

  // Only this stage's bit and WB's bit of the stall vector matter here.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Stage register: clear on reset or bubble, capture when not stalled, else hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      stg_valid       <= 1'b0;
      stg_pc          <= '0;
      stg_load        <= 1'b0;
      stg_ld_size     <= '0;
      stg_ld_unsigned <= 1'b0;
      stg_addr_lo     <= '0;
      stg_rf_we       <= 1'b0;
      stg_rf_waddr    <= '0;
      stg_result      <= '0;
    end else if (capture) begin
      stg_valid       <= ex_valid;
      stg_pc          <= ex_pc;
      stg_load        <= ex_load;
      stg_ld_size     <= ex_ld_size;
      stg_ld_unsigned <= ex_ld_unsigned;
      stg_addr_lo     <= ex_addr_lo;
      stg_rf_we       <= ex_rf_we;
      stg_rf_waddr    <= ex_rf_waddr;
      stg_result      <= ex_result;
    end
  end

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: a fresh entry resets tracking; otherwise WAIT -> HAVE on rvalid.
  always_comb begin
    state_next = state;
    if (capture) begin
      state_next = (ex_valid && ex_load) ? WAIT : IDLE;
    end else if (bubble) begin
      state_next = IDLE;
    end else if (resp_take) begin
      state_next = HAVE;
    end
  end

  // Captured load data, held for as long as the stage is stalled in HAVE.
  always_ff @(posedge clk) begin
    if (rst)            data_r <= '0;
    else if (resp_take) data_r <= aligned;
  end

`ifdef MEM_LOAD_SUBWORD_EN
  mem_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata       (dmem_rdata),
    .size        (stg_ld_size),
    .ld_unsigned (stg_ld_unsigned),
    .addr_lo     (stg_addr_lo),
    .aligned     (aligned)
  );
`else
  // Word-only build: loads return the raw read word.
  assign aligned = dmem_rdata;
  logic unused_subword;
  assign unused_subword = ^{stg_ld_size, stg_ld_unsigned, stg_addr_lo};
`endif

  // Write-data select: live response in WAIT, captured data in HAVE, else ALU result.
  always_comb begin
    wdata = stg_result;
    if (stg_load && state == HAVE)      wdata = data_r;
    else if (stg_load && state == WAIT) wdata = aligned;
  end

  assign stall_req   = (state == WAIT) & ~dmem_rvalid;
  assign fwd_pending = stall_req;

  assign wb_valid    = stg_valid;
  assign wb_pc       = stg_pc;
  assign wb_rf_we    = stg_valid & stg_rf_we;
  assign wb_rf_waddr = stg_rf_waddr;
  assign wb_rf_wdata = wdata;

  assign fwd_we      = wb_rf_we;
  assign fwd_waddr   = wb_rf_waddr;
  assign fwd_wdata   = wb_rf_wdata;

endmodule

// File: tb/tb_mem_stage_ld.sv
// Randomized self-checking bench for mem_stage_ld. Each instruction is a
// transaction (fields, response delay, read word, hold cycles); expected
// write data comes from an arithmetic load model. Works with or without
// MEM_LOAD_SUBWORD_EN.
module tb_mem_stage_ld;

  localparam int STG = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_load;
  logic [1:0]  ex_ld_size;
  logic        ex_ld_unsigned;
  logic [1:0]  ex_addr_lo;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_req;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        fwd_pending;

  always #5 clk = ~clk;

  mem_stage_ld dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_load        (ex_load),
    .ex_ld_size     (ex_ld_size),
    .ex_ld_unsigned (ex_ld_unsigned),
    .ex_addr_lo     (ex_addr_lo),
    .ex_rf_we       (ex_rf_we),
    .ex_rf_waddr    (ex_rf_waddr),
    .ex_result      (ex_result),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .stall_req      (stall_req),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_rf_we       (wb_rf_we),
    .wb_rf_waddr    (wb_rf_waddr),
    .wb_rf_wdata    (wb_rf_wdata),
    .fwd_we         (fwd_we),
    .fwd_waddr      (fwd_waddr),
    .fwd_wdata      (fwd_wdata),
    .fwd_pending    (fwd_pending)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  alo;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] result;
    int          n_wait;
    logic [31:0] rdata;
    int          holds;
    bit          leave_on_rv;
    logic [31:0] exp;
  } instr_t;

  int n_cmp = 0;
  int n_bad = 0;
  instr_t cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Load result from the architectural rules: shift the addressed lane down,
  // mask it, and subtract 2^w when a signed value has its top bit set.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] alo, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata;
`ifdef MEM_LOAD_SUBWORD_EN
    if (size == 2'd0) begin
      v = (rdata >> (8 * alo)) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (size == 2'd1) begin
      v = (rdata >> (alo >= 2'd2 ? 16 : 0)) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end
`endif
    return v;
  endfunction

  function automatic instr_t mk(input logic valid, input logic load, input logic [1:0] size,
                                input logic uns, input logic [1:0] alo, input logic [31:0] result,
                                input int n_wait, input logic [31:0] rdata, input int holds,
                                input bit leave_on_rv, input logic [31:0] exp);
    instr_t t;
    t.valid = valid; t.pc = 32'h1000 + result; t.load = load; t.size = size; t.uns = uns;
    t.alo = alo; t.we = valid; t.waddr = 5'd7; t.result = result; t.n_wait = n_wait;
    t.rdata = rdata; t.holds = holds; t.leave_on_rv = leave_on_rv; t.exp = exp;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.valid       = ($urandom_range(0, 9) != 0);
    t.load        = t.valid && ($urandom_range(0, 1) == 1);
    t.pc          = $urandom;
    t.size        = 2'($urandom_range(0, 2));
    t.uns         = 1'($urandom);
    t.alo         = 2'($urandom);
    t.we          = 1'($urandom);
    t.waddr       = 5'($urandom);
    t.result      = $urandom;
    t.n_wait      = $urandom_range(0, 4);
    t.rdata       = $urandom;
    t.holds       = $urandom_range(0, 2);
    t.leave_on_rv = 1'($urandom);
    t.exp         = model_load(t.size, t.uns, t.alo, t.rdata);
    return t;
  endfunction

  function automatic instr_t zero_instr(input int holds);
    instr_t t;
    t = mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 0, 32'h0, holds, 1'b0, 32'h0);
    t.pc = 32'h0; t.waddr = 5'd0;
    return t;
  endfunction

  function automatic logic [5:0] noise();
    return 6'($urandom) & ~(6'b11 << STG);
  endfunction

  // Stage and WB both stalled; EX carries junk that must be ignored.
  task automatic drive_hold();
    stall = noise() | (6'b11 << STG);
    ex_valid = 1'($urandom); ex_pc = $urandom; ex_load = 1'($urandom);
    ex_ld_size = 2'($urandom); ex_ld_unsigned = 1'($urandom); ex_addr_lo = 2'($urandom);
    ex_rf_we = 1'($urandom); ex_rf_waddr = 5'($urandom); ex_result = $urandom;
  endtask

  // Stage advances: either take nxt from EX or take a bubble.
  task automatic drive_leave(input instr_t nxt, input bit is_bubble);
    if (is_bubble) begin
      drive_hold();
      stall = noise() | (6'b1 << STG);
    end else begin
      stall = noise();
      ex_valid = nxt.valid; ex_pc = nxt.pc; ex_load = nxt.load; ex_ld_size = nxt.size;
      ex_ld_unsigned = nxt.uns; ex_addr_lo = nxt.alo; ex_rf_we = nxt.we;
      ex_rf_waddr = nxt.waddr; ex_result = nxt.result;
    end
  endtask

  // Compare every output against the transaction held in the stage.
  task automatic check_out(input bit pending);
    logic [31:0] exp;
    exp = cur.load ? cur.exp : cur.result;
    @(negedge clk);
    check("wb_valid", 32'(wb_valid), 32'(cur.valid));
    check("wb_pc", wb_pc, cur.pc);
    check("wb_rf_we", 32'(wb_rf_we), 32'(cur.valid & cur.we));
    check("wb_rf_waddr", 32'(wb_rf_waddr), 32'(cur.waddr));
    check("fwd_we", 32'(fwd_we), 32'(cur.valid & cur.we));
    check("fwd_waddr", 32'(fwd_waddr), 32'(cur.waddr));
    check("stall_req", 32'(stall_req), 32'(pending));
    check("fwd_pending", 32'(fwd_pending), 32'(pending));
    if (!pending) begin
      check("wb_rf_wdata", wb_rf_wdata, exp);
      check("fwd_wdata", fwd_wdata, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Run the current transaction to completion, handing the stage to nxt.
  task automatic run_phase(input instr_t nxt, input bit nxt_bubble);
    bit left;
    left = 1'b0;
    if (cur.load) begin
      for (int k = 0; k < cur.n_wait; k++) begin
        drive_hold();
        dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        check_out(1'b1);
      end
      dmem_rvalid = 1'b1; dmem_rdata = cur.rdata;
      if (cur.leave_on_rv) begin
        drive_leave(nxt, nxt_bubble);
        left = 1'b1;
      end else begin
        drive_hold();
      end
      check_out(1'b0);
    end
    if (!left) begin
      for (int k = 0; k < cur.holds; k++) begin
        drive_hold();
        dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
        check_out(1'b0);
      end
      drive_leave(nxt, nxt_bubble);
      dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
      check_out(1'b0);
    end
    cur = nxt_bubble ? zero_instr($urandom_range(0, 2)) : nxt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t d;
    bit b;
    logic [31:0] e;
    rst = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    drive_hold();
    cur = zero_instr(0);
    repeat (2) @(posedge clk);
    #1;
    check_out(1'b0);
    rst = 1'b0;

    // lb, offset 3, response next cycle.
`ifdef MEM_LOAD_SUBWORD_EN
    e = 32'hFFFF_FF80;
`else
    e = 32'h80FF_1234;
`endif
    d = mk(1'b1, 1'b1, 2'd0, 1'b0, 2'd3, 32'h10, 0, 32'h80FF_1234, 0, 1'b0, e);
    run_phase(d, 1'b0);
    // lhu, offset 2.
`ifdef MEM_LOAD_SUBWORD_EN
    e = 32'h0000_BEEF;
`else
    e = 32'hBEEF_0000;
`endif
    d = mk(1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 32'h20, 1, 32'hBEEF_0000, 1, 1'b1, e);
    run_phase(d, 1'b0);
    // lh, offset 2.
`ifdef MEM_LOAD_SUBWORD_EN
    e = 32'hFFFF_BEEF;
`else
    e = 32'hBEEF_0000;
`endif
    d = mk(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 32'h30, 0, 32'hBEEF_0000, 0, 1'b1, e);
    run_phase(d, 1'b0);
    // lw, response delayed 3 cycles.
    d = mk(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h40, 3, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D);
    run_phase(d, 1'b0);
    // add held two cycles, then replaced by a bubble.
    d = mk(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h1234_5678, 0, 32'h0, 2, 1'b0, 32'h0);
    run_phase(d, 1'b0);
    run_phase(d, 1'b1);
    // lb, offset 1.
`ifdef MEM_LOAD_SUBWORD_EN
    e = 32'h0000_0056;
`else
    e = 32'h1234_5678;
`endif
    d = mk(1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 32'h50, 2, 32'h1234_5678, 0, 1'b0, e);
    run_phase(d, 1'b0);

    for (int i = 0; i < 200; i++) begin
      b = ($urandom_range(0, 6) == 0);
      run_phase(rand_instr(), b);
    end

    // Reset while a load is waiting; a late response must be ignored.
    d = mk(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h60, 10, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
    run_phase(d, 1'b0);
    repeat (2) begin
      drive_hold();
      dmem_rvalid = 1'b0;
      check_out(1'b1);
    end
    rst = 1'b1;
    drive_hold();
    dmem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = zero_instr(0);
    drive_hold();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    check_out(1'b0);
    drive_hold();
    dmem_rvalid = 1'b0;
    check_out(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ld.md
# mem_stage_ld

Parametrised memory-access pipeline stage for the five-stage core, between EX and WB. It latches the EX result bus under the core stall vector and waits for variable-latency data-SRAM read responses. It aligns and sign/zero-extends sub-word loads, then drives the write-back bus and the ID forwarding bus. The forwarding bus carries a pending flag so ID can interlock on loads still in flight.

## Interface
Parameters:
- DATA_W, 32, datapath and SRAM read-data width (multiple of 16)
- RF_AW, 5, register-file address width
- STALL_W, 6, width of stall vector
- STG, 3, this stage's bit in the stall vector; STG+1 is WB's bit

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  core stall vector; 1 = stop
- ex_valid  in  1  EX slot holds an instruction
- ex_pc  in  32  instruction PC
- ex_load  in  1  instruction is a load
- ex_ld_size  in  2  00 byte, 01 half, 10 word
- ex_ld_unsigned  in  1  zero-extend (lbu/lhu)
- ex_addr_lo  in  2  low two bits of load address
- ex_rf_we, ex_rf_waddr, ex_result  in  1/RF_AW/DATA_W  write intent and ALU result
- dmem_rvalid  in  1  read data valid this cycle
- dmem_rdata  in  DATA_W  read data
- stall_req  out  1  request whole-pipe stall (load outstanding)
- wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata  out  to WB
- fwd_we, fwd_waddr, fwd_wdata  out  forwarding to ID
- fwd_pending  out  1  fwd_wdata not yet valid (load in flight)

## Operation
- Stage register updates on each clk edge:
  - rst: cleared, valid=0.
  - stall[STG]=1 and stall[STG+1]=0: loads a bubble, all fields 0.
  - stall[STG]=0: loads the ex_* fields.
  - Otherwise: holds.
- FSM states: IDLE, WAIT, HAVE. Reset state is IDLE.
  - Entering the register with a valid load sets WAIT. Any other entry sets IDLE.
  - In WAIT, dmem_rvalid=1 captures the aligned data into data_r and moves to HAVE.
  - HAVE holds until the register is replaced.
  - dmem_rvalid is ignored in IDLE and HAVE.
- stall_req = (state==WAIT) & ~dmem_rvalid.
- Load write data:
  - WAIT with rvalid: aligned dmem_rdata directly.
  - HAVE: data_r.
  - Non-load: ex_result.
- Alignment, on the low 32 bits:
  - Byte: lane ex_addr_lo.
  - Half: lane ex_addr_lo[1], with ex_addr_lo[0] ignored.
  - Word: passthrough.
  - Sign-extend unless ex_ld_unsigned.
- wb_* equal the registered fields and the selected write data. wb_rf_we is forced 0 when valid=0.
- fwd_* mirror wb_*. fwd_pending = stall_req.

## Timing
- Non-load: wb/fwd outputs valid in the cycle after the register captures.
- Load:
  - dmem_rvalid may assert at the earliest in the cycle after capture.
  - Latency is 1 + N cycles, where N is the number of rvalid-low cycles.
  - stall_req is high for exactly N cycles.
- rvalid arriving while stall[STG+1]=1: data is captured, and output holds stable from data_r.
- rst during WAIT: returns to IDLE and discards the response. A late rvalid is ignored.
- Reset values: every output 0, including stall_req and fwd_pending.

## Configuration
- MEM_LOAD_SUBWORD_EN defined: byte/half alignment and extension as above.
- MEM_LOAD_SUBWORD_EN undefined: ex_ld_size, ex_ld_unsigned and ex_addr_lo are ignored, and every load returns dmem_rdata unmodified. The alignment sub-module is not instantiated.

## Structure
- Shared package: LD_BYTE/LD_HALF/LD_WORD size encodings, FSM state encodings, STALL_W default, stage bus width constants.
- Sub-module mem_load_align (combinational): rdata, size, unsigned, addr_lo -> aligned word. Present only under MEM_LOAD_SUBWORD_EN.

## Test plan
- lb, addr_lo=3, rdata=0x80FF1234, rvalid in the next cycle -> wb_rf_wdata=0xFFFFFF80, stall_req never high.
- lhu, addr_lo=2, rdata=0xBEEF0000 -> wb_rf_wdata=0x0000BEEF. Same with lh -> 0xFFFFBEEF.
- lw with rvalid delayed 3 cycles -> stall_req and fwd_pending high for exactly 3 cycles, then wb_rf_wdata=rdata.
- stall[3]=1, stall[4]=0 with a valid add in EX -> next cycle wb_valid=0, wb_rf_we=0. stall[3]=stall[4]=1 -> outputs hold.
- rst asserted in WAIT, then rvalid pulsed -> all outputs 0, state IDLE, stall_req stays 0.
- MEM_LOAD_SUBWORD_EN undefined, lb addr_lo=1, rdata=0x12345678 -> wb_rf_wdata=0x12345678.
